// File: rtl/lpm_indication_serializer.sv
// lpm_indication_serializer
// Takes one packed LpmIndication message per pipe enq and emits it as
// 32-bit beats on the host word channel, least-significant word first.
// One message is held at a time. While it drains, the pipe is backpressured.
// On the final-beat handshake the pipe is ready again, so the next message
// follows with no idle cycle.
//
// state | meaning
// IDLE  | no message held; pipe ready, no beat presented
// SEND  | message held; beat presented until accepted by the word channel
module lpm_indication_serializer #(
  parameter int MSG_WIDTH  = 144,
  parameter int BEAT_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  pipe_enq__ENA,
  input  logic [MSG_WIDTH-1:0]  pipe_enq_v,
  output logic                  pipe_enq__RDY,
  output logic                  beat_enq__ENA,
  output logic [BEAT_WIDTH-1:0] beat_enq_v,
  output logic                  beat_last,
  input  logic                  beat_enq__RDY,
  output logic [31:0]           msg_count
);

  localparam int NBEATS = (MSG_WIDTH + BEAT_WIDTH - 1) / BEAT_WIDTH;
  localparam int HOLD_W = NBEATS * BEAT_WIDTH;
  localparam int IDX_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEATS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  beat_idx;
  logic [HOLD_W-1:0] hold;
  logic              beat_accept;
  logic              msg_load;

  // The holding register shifts down one beat per accept. The current beat is
  // therefore always in the low word, which is equivalent to indexing
  // hold[32*beat_idx +: 32] without needing a wide mux.
  assign beat_enq_v = hold[BEAT_WIDTH-1:0];

  // Ready while idle, and also on the final-beat handshake, so the next
  // message loads without a bubble.
  always_comb begin
    pipe_enq__RDY = (state == IDLE) || ((state == SEND) && beat_last && beat_enq__RDY);
    beat_accept   = (state == SEND) && beat_enq__RDY;
    msg_load      = pipe_enq__ENA && pipe_enq__RDY;
  end

  // Serializer FSM: handles beat advance, message completion and message capture.
  // When capture happens on the same cycle as the last beat, capture wins.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state         <= IDLE;
      beat_idx      <= '0;
      hold          <= '0;
      beat_enq__ENA <= 1'b0;
      beat_last     <= 1'b0;
      msg_count     <= '0;
    end else begin
      if (beat_accept) begin
        hold <= hold >> BEAT_WIDTH;
        if (beat_last) begin
          state         <= IDLE;
          beat_idx      <= '0;
          beat_enq__ENA <= 1'b0;
          beat_last     <= 1'b0;
          msg_count     <= msg_count + 32'd1;
        end else begin
          beat_idx  <= beat_idx + IDX_W'(1);
          beat_last <= ((beat_idx + IDX_W'(1)) == LAST_IDX);
        end
      end
      if (msg_load) begin
        state         <= SEND;
        beat_idx      <= '0;
        hold          <= HOLD_W'(pipe_enq_v);
        beat_enq__ENA <= 1'b1;
        beat_last     <= (LAST_IDX == '0);
      end
    end
  end

  // Upstream must only strobe when ready. A strobe while not ready is dropped above.
  enq_only_when_ready: assert property (@(posedge CLK) disable iff (!nRST)
    pipe_enq__ENA |-> pipe_enq__RDY);

  // The beat index stays within the message.
  beat_idx_in_range: assert property (@(posedge CLK) disable iff (!nRST)
    beat_idx <= LAST_IDX);

endmodule

// File: tb/tb_lpm_indication_serializer.sv
// Directed and randomized bench for lpm_indication_serializer.
module tb_lpm_indication_serializer;

  logic         CLK = 1'b0;
  logic         nRST;
  logic         pipe_enq__ENA;
  logic [143:0] pipe_enq_v;
  logic         pipe_enq__RDY;
  logic         beat_enq__ENA;
  logic [31:0]  beat_enq_v;
  logic         beat_last;
  logic         beat_enq__RDY;
  logic [31:0]  msg_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_count = 32'd0;

  lpm_indication_serializer #(.MSG_WIDTH(144), .BEAT_WIDTH(32)) dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .pipe_enq__ENA (pipe_enq__ENA),
    .pipe_enq_v    (pipe_enq_v),
    .pipe_enq__RDY (pipe_enq__RDY),
    .beat_enq__ENA (beat_enq__ENA),
    .beat_enq_v    (beat_enq_v),
    .beat_last     (beat_last),
    .beat_enq__RDY (beat_enq__RDY),
    .msg_count     (msg_count)
  );

  always #5 CLK = ~CLK;

  // Inputs are driven 1 ns after the rising edge. Outputs are sampled 1 ns after that.
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    nRST = 1'b0; pipe_enq__ENA = 1'b0; pipe_enq_v = '0; beat_enq__RDY = 1'b1;
    tick; tick;
    nRST = 1'b1;
    #1;
    checks++;
    if (beat_enq__ENA !== 1'b0 || beat_last !== 1'b0 || beat_enq_v !== 32'h0) begin
      errors++; $display("FAIL reset_beat ena=%b last=%b v=%h want 0 0 00000000", beat_enq__ENA, beat_last, beat_enq_v);
    end
    checks++;
    if (pipe_enq__RDY !== 1'b1 || msg_count !== 32'h0) begin
      errors++; $display("FAIL reset_pipe rdy=%b count=%h want 1 00000000", pipe_enq__RDY, msg_count);
    end
    // reset in the middle of a message, with beat 2 presented
    tick;
    pipe_enq__ENA = 1'b1;
    pipe_enq_v = {16'hA5A5, 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    tick;
    pipe_enq__ENA = 1'b0;
    tick; tick;
    #1;
    checks++;
    if (beat_enq__ENA !== 1'b1 || beat_enq_v !== 32'h33333333) begin
      errors++; $display("FAIL pre_reset_beat2 ena=%b v=%h want 1 33333333", beat_enq__ENA, beat_enq_v);
    end
    nRST = 1'b0;
    tick; tick;
    nRST = 1'b1;
    #1;
    checks++;
    if (beat_enq__ENA !== 1'b0 || pipe_enq__RDY !== 1'b1 || msg_count !== 32'h0 || beat_enq_v !== 32'h0) begin
      errors++; $display("FAIL midsend_reset ena=%b rdy=%b count=%h v=%h want 0 1 0 0",
                        beat_enq__ENA, pipe_enq__RDY, msg_count, beat_enq_v);
    end
    for (int i = 0; i < 6; i++) begin
      tick;
      checks++;
      if (beat_enq__ENA !== 1'b0) begin
        errors++; $display("FAIL stale_beat cycle %0d ena=%b want 0", i, beat_enq__ENA);
      end
    end
  endtask

  task automatic test_single;
    // Concatenation fields: {pad 16'h0, id 16'h5, data 32'hDEADBEEF, rsvd 64'h0, len 16'h40}
    logic [31:0] expv [5];
    expv[0] = 32'h00000040; expv[1] = 32'h00000000; expv[2] = 32'hBEEF0000;
    expv[3] = 32'h0005DEAD; expv[4] = 32'h00000000;
    beat_enq__RDY = 1'b1;
    pipe_enq__ENA = 1'b1;
    pipe_enq_v = {16'h0, 16'h5, 32'hDEADBEEF, 64'h0, 16'h40};
    tick;
    pipe_enq__ENA = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (beat_enq__ENA !== 1'b1 || beat_enq_v !== expv[i] || beat_last !== (i == 4)) begin
        errors++; $display("FAIL single_beat%0d ena=%b v=%h last=%b want 1 %h %b",
                          i, beat_enq__ENA, beat_enq_v, beat_last, expv[i], (i == 4));
      end
      checks++;
      if (pipe_enq__RDY !== (i == 4)) begin
        errors++; $display("FAIL single_pipe_rdy%0d got %b want %b", i, pipe_enq__RDY, (i == 4));
      end
      tick;
    end
    exp_count = exp_count + 32'd1;
    checks++;
    if (beat_enq__ENA !== 1'b0 || msg_count !== exp_count) begin
      errors++; $display("FAIL single_done ena=%b count=%h want 0 %h", beat_enq__ENA, msg_count, exp_count);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] expv [5];
    expv[0] = 32'h11111111; expv[1] = 32'h22222222; expv[2] = 32'h33333333;
    expv[3] = 32'h44444444; expv[4] = 32'h0000A5A5;
    beat_enq__RDY = 1'b1;
    pipe_enq__ENA = 1'b1;
    pipe_enq_v = {16'hA5A5, 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    tick;
    pipe_enq__ENA = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        beat_enq__RDY = 1'b0;
        for (int j = 0; j < 3; j++) begin
          #1;
          checks++;
          if (beat_enq__ENA !== 1'b1 || beat_enq_v !== expv[2] || beat_last !== 1'b0 || pipe_enq__RDY !== 1'b0) begin
            errors++; $display("FAIL stall%0d ena=%b v=%h last=%b rdy=%b want 1 %h 0 0",
                              j, beat_enq__ENA, beat_enq_v, beat_last, pipe_enq__RDY, expv[2]);
          end
          tick;
        end
        beat_enq__RDY = 1'b1;
      end
      #1;
      checks++;
      if (beat_enq__ENA !== 1'b1 || beat_enq_v !== expv[i] || beat_last !== (i == 4)) begin
        errors++; $display("FAIL bp_beat%0d ena=%b v=%h last=%b want 1 %h %b",
                          i, beat_enq__ENA, beat_enq_v, beat_last, expv[i], (i == 4));
      end
      tick;
    end
    exp_count = exp_count + 32'd1;
    checks++;
    if (beat_enq__ENA !== 1'b0 || msg_count !== exp_count) begin
      errors++; $display("FAIL bp_done ena=%b count=%h want 0 %h", beat_enq__ENA, msg_count, exp_count);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] expv [10];
    logic [31:0] want;
    expv[0] = 32'h00000040; expv[1] = 32'h00000000; expv[2] = 32'hBEEF0000;
    expv[3] = 32'h0005DEAD; expv[4] = 32'h00000000;
    expv[5] = 32'h55555555; expv[6] = 32'h66666666; expv[7] = 32'h77777777;
    expv[8] = 32'h88888888; expv[9] = 32'h00000F0F;
    beat_enq__RDY = 1'b1;
    pipe_enq__ENA = 1'b1;
    pipe_enq_v = {16'h0, 16'h5, 32'hDEADBEEF, 64'h0, 16'h40};
    tick;
    pipe_enq__ENA = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c == 4) begin
        pipe_enq__ENA = 1'b1;
        pipe_enq_v = {16'h0F0F, 32'h88888888, 32'h77777777, 32'h66666666, 32'h55555555};
      end
      #1;
      want = expv[c];
      checks++;
      if (beat_enq__ENA !== 1'b1 || beat_enq_v !== want || beat_last !== ((c % 5) == 4)) begin
        errors++; $display("FAIL b2b_beat%0d ena=%b v=%h last=%b want 1 %h %b",
                          c, beat_enq__ENA, beat_enq_v, beat_last, want, ((c % 5) == 4));
      end
      if (c == 4) begin
        checks++;
        if (pipe_enq__RDY !== 1'b1) begin
          errors++; $display("FAIL b2b_pipe_rdy got %b want 1", pipe_enq__RDY);
        end
      end
      tick;
      pipe_enq__ENA = 1'b0;
    end
    exp_count = exp_count + 32'd2;
    checks++;
    if (beat_enq__ENA !== 1'b0 || msg_count !== exp_count) begin
      errors++; $display("FAIL b2b_done ena=%b count=%h want 0 %h", beat_enq__ENA, msg_count, exp_count);
    end
  endtask

  task automatic test_wrap;
    beat_enq__RDY = 1'b1;
    force dut.msg_count = 32'hFFFFFFFF;
    tick;
    release dut.msg_count;
    pipe_enq__ENA = 1'b1;
    pipe_enq_v = {16'h1234, 32'hCAFEF00D, 32'h0, 32'hFFFFFFFF, 32'h1};
    tick;
    pipe_enq__ENA = 1'b0;
    repeat (5) tick;
    exp_count = 32'h0;
    checks++;
    if (beat_enq__ENA !== 1'b0 || msg_count !== 32'h0) begin
      errors++; $display("FAIL wrap ena=%b count=%h want 0 00000000", beat_enq__ENA, msg_count);
    end
  endtask

  task automatic test_random;
    logic [143:0] q [$];
    logic [159:0] asm_msg;
    logic [159:0] want;
    logic [159:0] r;
    logic         busy;
    int           midx;
    int           sent;
    int           recv;
    int           cyc;
    logic         exp_rdy;
    logic         prev_stall;
    logic [31:0]  prev_v;
    logic         prev_last;
    asm_msg = '0; busy = 1'b0; midx = 0; sent = 0; recv = 0; cyc = 0;
    prev_stall = 1'b0; prev_v = '0; prev_last = 1'b0;
    while (recv < 1000 && cyc < 40000) begin
      beat_enq__RDY = 1'($urandom_range(0, 1));
      exp_rdy = !busy || (midx == 4 && beat_enq__RDY);
      if (sent < 1000 && exp_rdy && $urandom_range(0, 9) < 7) begin
        r = {$urandom, $urandom, $urandom, $urandom, $urandom};
        pipe_enq__ENA = 1'b1;
        pipe_enq_v = r[143:0];
      end else begin
        pipe_enq__ENA = 1'b0;
      end
      #1;
      checks++;
      if (pipe_enq__RDY !== exp_rdy || beat_enq__ENA !== busy || (busy && beat_last !== (midx == 4))) begin
        errors++; $display("FAIL rnd_ctrl cyc %0d rdy=%b ena=%b last=%b want %b %b idx %0d",
                          cyc, pipe_enq__RDY, beat_enq__ENA, beat_last, exp_rdy, busy, midx);
      end
      if (prev_stall) begin
        checks++;
        if (beat_enq_v !== prev_v || beat_last !== prev_last) begin
          errors++; $display("FAIL rnd_stall cyc %0d v=%h last=%b want %h %b", cyc, beat_enq_v, beat_last, prev_v, prev_last);
        end
      end
      if (busy && beat_enq__RDY) begin
        asm_msg[32*midx +: 32] = beat_enq_v;
        if (midx == 4) begin
          checks++;
          if (q.size() == 0) begin
            errors++; $display("FAIL rnd_underflow cyc %0d got beats with no message queued", cyc);
          end else begin
            want = {16'h0, q.pop_front()};
            if (asm_msg !== want) begin
              errors++; $display("FAIL rnd_msg%0d got %h want %h", recv, asm_msg, want);
            end
          end
          recv++;
        end
      end
      prev_stall = busy && !beat_enq__RDY;
      prev_v = beat_enq_v;
      prev_last = beat_last;
      if (busy && beat_enq__RDY) begin
        if (midx == 4) begin
          busy = 1'b0; midx = 0; exp_count = exp_count + 32'd1;
        end else begin
          midx++;
        end
      end
      if (pipe_enq__ENA && exp_rdy) begin
        q.push_back(pipe_enq_v);
        sent++;
        busy = 1'b1;
        midx = 0;
      end
      tick;
      pipe_enq__ENA = 1'b0;
      cyc++;
    end
    checks++;
    if (recv != 1000) begin
      errors++; $display("FAIL rnd_timeout received %0d want 1000 in %0d cycles", recv, cyc);
    end
    checks++;
    if (msg_count !== exp_count) begin
      errors++; $display("FAIL rnd_count got %h want %h", msg_count, exp_count);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_backpressure;
    test_back_to_back;
    test_wrap;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
